axi_stride_reader: RTL and testbench

- AXI read-traffic master that drives the slave-side read channels (s_ar_*, s_r_*) of prefetcherTop.
- Emulates the strided read stream of an accelerator client: issues N bursts at base + k*stride, consumes all R beats, checks ID and LAST framing, and reports completion and errors.
- Serves as the upstream stimulus stage in prefetcher-plus-memory-stub system benches and as a standalone traffic engine.

---
 rtl/axi_stride_reader_pkg.sv | 18 +
 rtl/stride_addr_gen.sv | 45 ++++
 rtl/axi_stride_reader.sv | 200 ++++++++++++++++++++
 tb/tb_axi_stride_reader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stride_reader_pkg.sv
// Shared types and default widths for the strided AXI read traffic engine.
package axi_stride_reader_pkg;

    localparam int unsigned DEF_ADDR_BITS       = 64;
    localparam int unsigned DEF_BURST_LEN_WIDTH = 8;
    localparam int unsigned DEF_TID_WIDTH       = 4;
    localparam int unsigned DEF_DATA_WIDTH      = 64;
    localparam int unsigned DEF_CNT_WIDTH       = 16;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stride_addr_gen.sv
// Burst address generator: base + k*stride, plus issued-burst bookkeeping against the latched count.
module stride_addr_gen
    import axi_stride_reader_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
)(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] cfg_base,
    input  logic [ADDR_BITS-1:0] cfg_stride,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic                 advance,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 all_issued,
    output logic                 final_pending
);

    logic [ADDR_BITS-1:0] stride_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] issued_q;

    // Address wraps modulo 2^ADDR_BITS; a negative stride is just a large unsigned addend.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            addr     <= '0;
            stride_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
        end else if (load) begin
            addr     <= cfg_base;
            stride_q <= cfg_stride;
            count_q  <= cfg_count;
            issued_q <= '0;
        end else if (advance) begin
            addr     <= addr + stride_q;
            issued_q <= issued_q + CNT_WIDTH'(1);
        end
    end

    assign all_issued    = (issued_q == count_q);
    assign final_pending = ((issued_q + CNT_WIDTH'(1)) == count_q);

endmodule

// File: rtl/axi_stride_reader.sv
// Strided AXI read master: issues cfg_count bursts at base + k*stride and checks R framing.
// Optional STRIDE_READER_CHECKSUM_EN adds an XOR checksum of all received R data.
module axi_stride_reader
    import axi_stride_reader_pkg::*;
#(
    parameter int unsigned ADDR_BITS       = DEF_ADDR_BITS,
    parameter int unsigned BURST_LEN_WIDTH = DEF_BURST_LEN_WIDTH,
    parameter int unsigned TID_WIDTH       = DEF_TID_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
)(
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       cfg_base,
    input  logic [ADDR_BITS-1:0]       cfg_stride,
    input  logic [CNT_WIDTH-1:0]       cfg_count,
    input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
    input  logic [TID_WIDTH-1:0]       cfg_id,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [TID_WIDTH-1:0]       m_ar_id,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic                       m_r_last,
    input  logic [TID_WIDTH-1:0]       m_r_id,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       beatCnt,
    output logic                       errId,
    output logic                       errLast
`ifdef STRIDE_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]      checksum
`endif
);

    // state | meaning
    // IDLE  | waiting for start, no traffic
    // ISSUE | issuing AR bursts (throttled by outstanding), accepting R
    // DRAIN | all AR issued, accepting R until nothing is outstanding
    // DONE  | run finished, done held high, start restarts

    localparam int unsigned         OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]    OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    state_t                     state;
    logic [OUT_W-1:0]           outstanding;
    logic [OUT_W-1:0]           out_next;
    logic [BURST_LEN_WIDTH-1:0] beat_idx;
    logic                       ar_hs;
    logic                       r_hs;
    logic                       r_stray;
    logic                       r_end;
    logic                       start_ok;
    logic                       start_go;
    logic                       all_issued;
    logic                       final_pending;
    logic                       issue_complete;

    assign ar_hs    = m_ar_valid & m_ar_ready;
    assign r_hs     = m_r_valid & m_r_ready;
    assign r_stray  = r_hs & (outstanding == '0);
    assign r_end    = r_hs & ~r_stray & (m_r_last | (beat_idx == m_ar_len));
    assign start_ok = start & ((state == IDLE) | (state == DONE));
    assign start_go = start_ok & (cfg_count != '0);

    always_comb begin
        out_next = outstanding;
        if (ar_hs && !r_end) begin
            out_next = outstanding + OUT_W'(1);
        end else if (!ar_hs && r_end) begin
            out_next = outstanding - OUT_W'(1);
        end
    end

    assign issue_complete = all_issued | (ar_hs & final_pending);

    stride_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_addr_gen (
        .clk           (clk),
        .resetN        (resetN),
        .load          (start_go),
        .cfg_base      (cfg_base),
        .cfg_stride    (cfg_stride),
        .cfg_count     (cfg_count),
        .advance       (ar_hs),
        .addr          (m_ar_addr),
        .all_issued    (all_issued),
        .final_pending (final_pending)
    );

    // m_ar_valid is recomputed from next-cycle bookkeeping, so it cannot drop while waiting for ready.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            m_ar_valid  <= 1'b0;
            m_r_ready   <= 1'b0;
            m_ar_len    <= '0;
            m_ar_id     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            outstanding <= '0;
        end else begin
            outstanding <= out_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (cfg_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            m_ar_len   <= cfg_len;
                            m_ar_id    <= cfg_id;
                            m_ar_valid <= 1'b1;
                            m_r_ready  <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_complete) begin
                        state      <= DRAIN;
                        m_ar_valid <= 1'b0;
                    end else begin
                        m_ar_valid <= (out_next < OUT_MAX);
                    end
                end
                DRAIN: begin
                    if (out_next == '0) begin
                        state     <= DONE;
                        m_r_ready <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            beat_idx <= '0;
            beatCnt  <= '0;
            errId    <= 1'b0;
            errLast  <= 1'b0;
        end else if (start_go) begin
            beat_idx <= '0;
            beatCnt  <= '0;
            errId    <= 1'b0;
            errLast  <= 1'b0;
        end else if (r_hs) begin
            if (beatCnt != '1) begin
                beatCnt <= beatCnt + CNT_WIDTH'(1);
            end
            if (m_r_id != m_ar_id) begin
                errId <= 1'b1;
            end
            // A beat with nothing outstanding is swallowed and flagged as a framing error.
            if (r_stray) begin
                errLast  <= 1'b1;
                beat_idx <= '0;
            end else if (r_end) begin
                if (m_r_last != (beat_idx == m_ar_len)) begin
                    errLast <= 1'b1;
                end
                beat_idx <= '0;
            end else begin
                beat_idx <= beat_idx + BURST_LEN_WIDTH'(1);
            end
        end
    end

`ifdef STRIDE_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (r_hs) begin
            checksum <= checksum ^ m_r_data;
        end
    end
`else
    logic r_data_unused;
    assign r_data_unused = ^m_r_data;
`endif

endmodule

// File: tb/tb_axi_stride_reader.sv
// Self-checking bench: AXI slave stub plus a burst-level reference model of the strided read stream.
module tb_axi_stride_reader;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic [63:0] cfg_base;
    logic [63:0] cfg_stride;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_len;
    logic [3:0]  cfg_id;
    logic        m_ar_valid;
    logic        m_ar_ready;
    logic [63:0] m_ar_addr;
    logic [7:0]  m_ar_len;
    logic [3:0]  m_ar_id;
    logic        m_r_valid;
    logic        m_r_ready;
    logic [63:0] m_r_data;
    logic        m_r_last;
    logic [3:0]  m_r_id;
    logic        busy;
    logic        done;
    logic [15:0] beatCnt;
    logic        errId;
    logic        errLast;
`ifdef STRIDE_READER_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    axi_stride_reader dut (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start),
        .cfg_base   (cfg_base),
        .cfg_stride (cfg_stride),
        .cfg_count  (cfg_count),
        .cfg_len    (cfg_len),
        .cfg_id     (cfg_id),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_ar_addr  (m_ar_addr),
        .m_ar_len   (m_ar_len),
        .m_ar_id    (m_ar_id),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready),
        .m_r_data   (m_r_data),
        .m_r_last   (m_r_last),
        .m_r_id     (m_r_id),
        .busy       (busy),
        .done       (done),
        .beatCnt    (beatCnt),
        .errId      (errId),
        .errLast    (errLast)
`ifdef STRIDE_READER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] base;
        logic [63:0] stride;
        logic [15:0] count;
        logic [7:0]  len;
        logic [3:0]  id;
        int          ready_mode;
        int          gap;
        int          id_err_beat;
        int          miss_last_burst;
        int          exp_beats;
        bit          exp_err_id;
        bit          exp_err_last;
        logic [63:0] exp_last_addr;
        bit          exp_full;
    } vec_t;

    vec_t vecs[8];

    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  pend_len[$];
    logic [63:0] cap_addr[$];
    logic [3:0]  cap_id[$];
    logic [7:0]  cap_len[$];
    int          model_out, beat_idx, burst_no, beats_sent, gap_cnt, gap_cfg;
    int          ready_mode, id_err_beat, miss_last_burst;
    bit          stray_req, stray_beat, r_acc, saw_full, prev_ar_wait;
    logic [63:0] xsum, prev_addr;
    logic [7:0]  prev_len;
    logic [3:0]  prev_id, cur_id;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_stub();
        pend_len.delete();
        cap_addr.delete();
        cap_id.delete();
        cap_len.delete();
        model_out = 0; beat_idx = 0; burst_no = 0; beats_sent = 0; gap_cnt = 0;
        stray_req = 0; stray_beat = 0; r_acc = 0; saw_full = 0; prev_ar_wait = 0;
        xsum = '0;
        m_r_valid = 0; m_r_last = 0; m_r_id = '0; m_r_data = '0; m_ar_ready = 0;
    endtask

    // One clock: runs at the falling edge, decides what the next rising edge will transfer.
    task automatic cycle();
        @(negedge clk);
        if (r_acc) begin
            m_r_valid = 0;
            r_acc     = 0;
            gap_cnt   = (gap_cfg < 0) ? $urandom_range(0, 3) : gap_cfg;
        end
        if (model_out >= MAX_OUT) begin
            saw_full = 1;
            check("ar_valid_when_full", m_ar_valid, 0);
        end
        if (prev_ar_wait) begin
            check("ar_hold_valid", m_ar_valid, 1);
            check("ar_hold_addr", m_ar_addr, prev_addr);
            check("ar_hold_len", m_ar_len, prev_len);
            check("ar_hold_id", m_ar_id, prev_id);
        end
        if (!m_r_valid) begin
            if (gap_cnt > 0) begin
                gap_cnt--;
            end else if (stray_req) begin
                m_r_valid = 1; m_r_last = 1; m_r_id = cur_id;
                m_r_data = {$urandom, $urandom};
                stray_req = 0; stray_beat = 1;
            end else if (pend_len.size() > 0) begin
                m_r_valid = 1;
                m_r_data  = {$urandom, $urandom};
                m_r_last  = (beat_idx == int'(pend_len[0]));
                if (m_r_last && burst_no == miss_last_burst) m_r_last = 0;
                m_r_id = (beats_sent == id_err_beat) ? cur_id + 4'd1 : cur_id;
            end
        end
        if (m_r_valid && m_r_ready) begin
            r_acc = 1;
            beats_sent++;
            xsum ^= m_r_data;
            if (stray_beat) begin
                stray_beat = 0;
            end else if (beat_idx == int'(pend_len[0])) begin
                void'(pend_len.pop_front());
                beat_idx = 0;
                burst_no++;
                model_out--;
            end else begin
                beat_idx++;
            end
        end
        case (ready_mode)
            0:       m_ar_ready = 1;
            1:       m_ar_ready = 1'($urandom_range(0, 1));
            default: m_ar_ready = 0;
        endcase
        prev_ar_wait = m_ar_valid && !m_ar_ready;
        prev_addr = m_ar_addr; prev_len = m_ar_len; prev_id = m_ar_id;
        if (m_ar_valid && m_ar_ready) begin
            cap_addr.push_back(m_ar_addr);
            cap_id.push_back(m_ar_id);
            cap_len.push_back(m_ar_len);
            pend_len.push_back(m_ar_len);
            model_out++;
        end
    endtask

    task automatic run(input vec_t v);
        logic [63:0] ea;
        reset_stub();
        ready_mode = v.ready_mode; gap_cfg = v.gap;
        id_err_beat = v.id_err_beat; miss_last_burst = v.miss_last_burst;
        cfg_base = v.base; cfg_stride = v.stride; cfg_count = v.count;
        cfg_len = v.len; cfg_id = v.id; cur_id = v.id;
        start = 1;
        cycle();
        start = 0;
        for (int c = 0; c < 4000 && !done; c++) cycle();
        check("done_reached", done, 1);
        check("busy_in_done", busy, 0);
        check("ar_valid_in_done", m_ar_valid, 0);
        check("r_ready_in_done", m_r_ready, 0);
        check("beat_count", beatCnt, v.exp_beats);
        check("err_id", errId, v.exp_err_id);
        check("err_last", errLast, v.exp_err_last);
        check("ar_count", cap_addr.size(), v.count);
        for (int k = 0; k < cap_addr.size(); k++) begin
            ea = v.base + 64'(k) * v.stride;
            check("ar_addr", cap_addr[k], ea);
            check("ar_id", cap_id[k], v.id);
            check("ar_len", cap_len[k], v.len);
        end
        if (cap_addr.size() > 0) check("ar_last_addr", cap_addr[cap_addr.size()-1], v.exp_last_addr);
        if (v.exp_full) check("reached_max_outstanding", saw_full, 1);
`ifdef STRIDE_READER_CHECKSUM_EN
        check("checksum", checksum, xsum);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ar_valid"}, m_ar_valid, 0);
        check({tag, "_r_ready"}, m_r_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_beat_count"}, beatCnt, 0);
        check({tag, "_err_id"}, errId, 0);
        check({tag, "_err_last"}, errLast, 0);
`ifdef STRIDE_READER_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, 0);
`endif
    endtask

    initial begin
        vec_t v;
        bit   ar_seen;
        int   beats;

        //          base                    stride                  cnt len id rm gap ideb mlb beats eid elast last_addr              full
        vecs[0] = '{64'h10,                 64'h4,                  3,  0,  5, 0, 0,  -1,  -1, 3,    0,  0,    64'h18,                0};
        vecs[1] = '{64'h1000,               64'h40,                 2,  3,  5, 0, 4,  -1,  -1, 8,    0,  0,    64'h1040,              0};
        vecs[2] = '{64'h1000,               64'h40,                 6,  3,  2, 0, 4,  -1,  -1, 24,   0,  0,    64'h1140,              1};
        vecs[3] = '{64'h200,                64'h10,                 3,  3,  5, 1, 1,  2,   -1, 12,   1,  0,    64'h220,               0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h8,                 2,  0,  1, 0, 0,  -1,  -1, 2,    0,  0,    64'h4,                 0};
        vecs[5] = '{64'h300,                64'h20,                 2,  1,  9, 0, 0,  -1,  1,  4,    0,  1,    64'h320,               0};
        vecs[6] = '{64'h100,                64'hFFFF_FFFF_FFFF_FFE0, 4,  1,  3, 1, 2,  -1,  -1, 8,    0,  0,    64'hA0,                0};
        vecs[7] = '{64'h0,                  64'h80,                 1,  7, 15, 0, 0,  7,   -1, 8,    1,  0,    64'h0,                 0};

        resetN = 0; start = 0;
        cfg_base = '0; cfg_stride = '0; cfg_count = '0; cfg_len = '0; cfg_id = '0;
        ready_mode = 0; gap_cfg = 0; id_err_beat = -1; miss_last_burst = -1; cur_id = '0;
        reset_stub();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetN = 1;
        cycle();

        // count = 0: straight to DONE, never an AR
        reset_stub();
        cfg_count = '0;
        start = 1;
        cycle();
        start = 0;
        check("zero_count_done", done, 1);
        check("zero_count_busy", busy, 0);
        ar_seen = m_ar_valid;
        for (int c = 0; c < 5; c++) begin
            cycle();
            ar_seen |= m_ar_valid;
        end
        check("zero_count_no_ar", ar_seen, 0);
        check("zero_count_no_r_ready", m_r_ready, 0);

        for (int i = 0; i < 8; i++) run(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            v.base   = {$urandom, $urandom};
            v.stride = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255)) << 3;
            v.count  = 16'($urandom_range(1, 8));
            v.len    = 8'($urandom_range(0, 3));
            v.id     = 4'($urandom_range(0, 15));
            v.ready_mode = $urandom_range(0, 1);
            v.gap    = -1;
            beats    = int'(v.count) * (int'(v.len) + 1);
            v.id_err_beat     = ($urandom_range(0, 2) == 0) ? $urandom_range(0, beats - 1) : -1;
            v.miss_last_burst = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(v.count) - 1) : -1;
            v.exp_beats     = beats;
            v.exp_err_id    = (v.id_err_beat >= 0);
            v.exp_err_last  = (v.miss_last_burst >= 0);
            v.exp_last_addr = v.base + 64'(int'(v.count) - 1) * v.stride;
            v.exp_full      = 0;
            run(v);
        end

        // Stray R beat while nothing is outstanding
        reset_stub();
        ready_mode = 2; gap_cfg = 0; id_err_beat = -1; miss_last_burst = -1;
        cfg_base = 64'h800; cfg_stride = 64'h10; cfg_count = 1; cfg_len = 0; cfg_id = 3; cur_id = 3;
        start = 1;
        cycle();
        start = 0;
        cycle();
        cycle();
        stray_req = 1;
        for (int c = 0; c < 20 && beats_sent == 0; c++) cycle();
        cycle();
        check("stray_err_last", errLast, 1);
        check("stray_beat_count", beatCnt, 1);
        check("stray_busy", busy, 1);
        ready_mode = 0;
        for (int c = 0; c < 200 && !done; c++) cycle();
        check("stray_done", done, 1);
        check("stray_final_beats", beatCnt, 2);
        check("stray_err_last_sticky", errLast, 1);
        check("stray_err_id", errId, 0);

        // Reset in DRAIN with two bursts outstanding, then a clean single-burst run
        reset_stub();
        ready_mode = 0; gap_cfg = 30;
        cfg_base = 64'h4000; cfg_stride = 64'h100; cfg_count = 2; cfg_len = 3; cfg_id = 7; cur_id = 7;
        start = 1;
        cycle();
        start = 0;
        for (int c = 0; c < 50 && cap_addr.size() < 2; c++) cycle();
        cycle();
        cycle();
        check("drain_busy", busy, 1);
        check("drain_ar_valid", m_ar_valid, 0);
        check("drain_done", done, 0);
        check("drain_outstanding_model", model_out, 2);
        resetN = 0;
        #1;
        check_reset_outputs("mid_reset");
        reset_stub();
        @(negedge clk);
        @(negedge clk);
        resetN = 1;
        v = '{64'h500, 64'h10, 1, 1, 4, 0, 0, -1, -1, 2, 0, 0, 64'h500, 0};
        run(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
